port_status_ctrl: RTL and testbench
===================================

Name: port_status_ctrl

Overview:
- Per-output-port credit tracker and status scheduler for the 2x2 permuter-block network inside the router.
- Keeps one downstream-buffer credit counter and one small FSM per output port.
- Drives the registered 4*`PORT_STAT_SIZE` portStatus bus read by every permuter block. Permuter blocks suppress swaps toward ports marked `INACTIVE`.
- Handles link enable/disable with drain sequencing, so a port is never torn down while flits are still in flight.

Parameters:
- CREDIT_MAX, 4, downstream buffer depth in flits; the reset and full value of each credit counter.
- RESUME_THRESH, 2, credits required to leave STALLED (used only with STATUS_HYST_EN).
- CW, 3, credit counter width; must hold CREDIT_MAX.

Ports:
- clk  in  1  router clock.
- rst_n  in  1  asynchronous, active-low reset.
- linkEnable  in  4  per-port configuration enable, quasi-static. Bit i maps to port i.
- flitSent  in  4  a valid flit left output port i this cycle; consumes 1 credit.
- creditReturn  in  4  downstream freed one buffer slot for port i; returns 1 credit.
- portStatus  out  4*`PORT_STAT_SIZE`  slice i is the status of port i; encodings `ACTIVE`/`INACTIVE` from globalVariable.v.
- creditCount  out  4*CW  debug view of the counters; slice i belongs to port i.
- errUnderflow  out  4  sticky: flitSent seen while credits==0.
- errOverflow  out  4  sticky: creditReturn seen while credits==CREDIT_MAX.

Behaviour:
- Reset (async assert, sync release):
  - all counters = CREDIT_MAX;
  - every FSM = OFF;
  - portStatus = all `INACTIVE`;
  - err* = 0.
- Credit update per port, applied every cycle in every state:
  - next = cnt - flitSent + creditReturn.
  - Simultaneous send and return: net 0, no error.
  - Send at 0: counter holds 0 and errUnderflow[i] sets.
  - Return at CREDIT_MAX: counter holds CREDIT_MAX and errOverflow[i] sets.
  - Counters never wrap.
- FSM per port, states OFF, ACTIVE, STALLED, DRAIN. Transitions are evaluated on the next-cycle counter value (nextCnt):
  - OFF -> ACTIVE when linkEnable[i]=1 and nextCnt==CREDIT_MAX. Otherwise stay OFF.
  - ACTIVE -> DRAIN when linkEnable[i]=0 (highest priority).
  - ACTIVE -> STALLED when nextCnt==0.
  - STALLED -> DRAIN when linkEnable[i]=0.
  - STALLED -> ACTIVE when the resume condition holds.
  - DRAIN -> OFF when nextCnt==CREDIT_MAX.
  - DRAIN -> ACTIVE if linkEnable[i] re-asserts before drain completes.
- Output mapping: portStatus slice i is `ACTIVE` only in state ACTIVE; `INACTIVE` in OFF, STALLED and DRAIN.
- Latency: portStatus is a register loaded from the next state, so an event in cycle t is visible at t+1.
  - Example: in cycle t the port has 1 credit and a flit is sent. At t+1 the counter is 0 and the status is `INACTIVE`.
  - The permuter therefore never routes into a port with 0 credits, provided downstream honours the count.
- Ports are fully independent. No cross-port priority or shared state.
- rst_n asserted mid-operation: immediate return to reset values. In-flight credits are discarded; downstream must reset together with this block.

Optional Feature:
- STATUS_HYST_EN defined: STALLED -> ACTIVE requires nextCnt >= RESUME_THRESH. This gives hysteresis against status toggling every cycle.
- Not defined: STALLED -> ACTIVE when nextCnt >= 1, and RESUME_THRESH is ignored.
- In both cases, reset values and all other transitions are unchanged.

Decomposition:
- globalVariable.v gains:
  - `PSC_OFF`, `PSC_ACTIVE`, `PSC_STALLED`, `PSC_DRAIN` 2-bit state codes;
  - `CREDIT_MAX_DEF`, `RESUME_THRESH_DEF`.
- `ACTIVE`, `INACTIVE` and `PORT_STAT_SIZE` are reused from globalVariable.v as they are.
- One sub-module, port_credit_fsm: a single port's counter, FSM, error flags and status register. The top instantiates 4 copies in a generate loop and packs the buses.

Test Plan:
- Reset, then linkEnable=4'hF at cycle 0 -> all ports `ACTIVE` at cycle 1; creditCount = 4 each.
- Port 2: flitSent[2] held high 4 cycles, no returns -> counter 3,2,1,0; status `INACTIVE` in the cycle after the 4th send; port 2 FSM = STALLED; other ports stay `ACTIVE`.
- From STALLED, one creditReturn[2] pulse:
  - without STATUS_HYST_EN -> `ACTIVE` next cycle;
  - with it (RESUME_THRESH=2) -> stays `INACTIVE` until the 2nd return, then `ACTIVE`.
- Port 0 at 2 credits, flitSent[0] and creditReturn[0] both high for 3 cycles -> counter stays 2, status stays `ACTIVE`, no errors.
- Port 1 at 1 credit, linkEnable[1] dropped -> DRAIN with `INACTIVE` next cycle. After 3 returns -> OFF. linkEnable[1] re-raised -> `ACTIVE` 1 cycle later.
- Port 3 at 0 credits, flitSent[3] pulsed -> errUnderflow[3]=1 and sticky, counter 0. A return at full count on port 0 -> errOverflow[0]=1. rst_n pulsed low mid-test -> every err bit 0, counters 4, all `INACTIVE` asynchronously.

Source files
------------

// File: rtl/port_status_ctrl_pkg.sv
// Shared types and constants for the per-port credit tracker / status scheduler.
package port_status_ctrl_pkg;

    localparam int unsigned NUM_PORTS         = 4;
    localparam int unsigned PORT_STAT_SIZE    = 1;
    localparam int unsigned CREDIT_MAX_DEF    = 4;
    localparam int unsigned RESUME_THRESH_DEF = 2;
    localparam int unsigned CW_DEF            = 3;

    localparam logic [PORT_STAT_SIZE-1:0] STAT_ACTIVE   = PORT_STAT_SIZE'(1);
    localparam logic [PORT_STAT_SIZE-1:0] STAT_INACTIVE = PORT_STAT_SIZE'(0);

    typedef enum logic [1:0] {
        PSC_OFF     = 2'd0,
        PSC_ACTIVE  = 2'd1,
        PSC_STALLED = 2'd2,
        PSC_DRAIN   = 2'd3
    } psc_state_e;

    // One port's per-cycle request bundle.
    typedef struct packed {
        logic link_enable;
        logic flit_sent;
        logic credit_return;
    } port_req_t;

    // Only a fully ACTIVE port may be targeted by the permuter blocks.
    function automatic logic [PORT_STAT_SIZE-1:0] status_of(input psc_state_e s);
        return (s == PSC_ACTIVE) ? STAT_ACTIVE : STAT_INACTIVE;
    endfunction

endpackage

// File: rtl/port_status_ctrl_port_credit_fsm.sv
// Single output port: credit counter, OFF/ACTIVE/STALLED/DRAIN FSM, sticky errors, status register.
// STATUS_HYST_EN: when defined, leaving STALLED needs RESUME_THRESH credits instead of one.
module port_credit_fsm
    import port_status_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_MAX    = CREDIT_MAX_DEF,
    parameter int unsigned RESUME_THRESH = RESUME_THRESH_DEF,
    parameter int unsigned CW            = CW_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  port_req_t                 i_req,
    output logic [PORT_STAT_SIZE-1:0] o_status,
    output logic [CW-1:0]             o_credit_count,
    output logic                      o_err_underflow,
    output logic                      o_err_overflow
);

    localparam logic [CW-1:0] CNT_FULL = CW'(CREDIT_MAX);
`ifdef STATUS_HYST_EN
    localparam logic [CW-1:0] RESUME_LVL = CW'(RESUME_THRESH);
`else
    localparam logic [CW-1:0] RESUME_LVL = CW'(1);
`endif

    if ((CREDIT_MAX >= (1 << CW)) || (RESUME_THRESH > CREDIT_MAX)) begin : g_bad_cfg
        $error("port_credit_fsm: CW too narrow for CREDIT_MAX or RESUME_THRESH above CREDIT_MAX");
    end

    psc_state_e                r_state;
    psc_state_e                w_state_next;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             w_next_cnt;
    logic [PORT_STAT_SIZE-1:0] r_status;
    logic                      r_err_uf;
    logic                      r_err_of;
    logic                      w_send_only;
    logic                      w_ret_only;
    logic                      w_underflow;
    logic                      w_overflow;

    // A simultaneous send and return cancel and can never flag an error.
    assign w_send_only = i_req.flit_sent & ~i_req.credit_return;
    assign w_ret_only  = i_req.credit_return & ~i_req.flit_sent;
    assign w_underflow = w_send_only && (r_cnt == '0);
    assign w_overflow  = w_ret_only && (r_cnt == CNT_FULL);

    always_comb begin
        w_next_cnt = r_cnt;
        if (w_send_only && !w_underflow) begin
            w_next_cnt = r_cnt - CW'(1);
        end else if (w_ret_only && !w_overflow) begin
            w_next_cnt = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PSC_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Transitions look at the post-update counter so status never lags credits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PSC_OFF: begin
                if (i_req.link_enable && (w_next_cnt == CNT_FULL)) w_state_next = PSC_ACTIVE;
            end
            PSC_ACTIVE: begin
                if (!i_req.link_enable)      w_state_next = PSC_DRAIN;
                else if (w_next_cnt == '0)   w_state_next = PSC_STALLED;
            end
            PSC_STALLED: begin
                if (!i_req.link_enable)             w_state_next = PSC_DRAIN;
                else if (w_next_cnt >= RESUME_LVL)  w_state_next = PSC_ACTIVE;
            end
            PSC_DRAIN: begin
                if (w_next_cnt == CNT_FULL)  w_state_next = PSC_OFF;
                else if (i_req.link_enable)  w_state_next = PSC_ACTIVE;
            end
            default: w_state_next = PSC_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= CNT_FULL;
            r_status <= STAT_INACTIVE;
            r_err_uf <= 1'b0;
            r_err_of <= 1'b0;
        end else begin
            r_cnt    <= w_next_cnt;
            r_status <= status_of(w_state_next);
            r_err_uf <= r_err_uf | w_underflow;
            r_err_of <= r_err_of | w_overflow;
        end
    end

    assign o_status        = r_status;
    assign o_credit_count  = r_cnt;
    assign o_err_underflow = r_err_uf;
    assign o_err_overflow  = r_err_of;

endmodule

// File: rtl/port_status_ctrl.sv
// Four independent output-port credit trackers packed onto the portStatus / debug buses.
// STATUS_HYST_EN (see port_credit_fsm) selects the STALLED resume threshold.
module port_status_ctrl
    import port_status_ctrl_pkg::*;
#(
    parameter int unsigned CREDIT_MAX    = CREDIT_MAX_DEF,
    parameter int unsigned RESUME_THRESH = RESUME_THRESH_DEF,
    parameter int unsigned CW            = CW_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS-1:0]                linkEnable,
    input  logic [NUM_PORTS-1:0]                flitSent,
    input  logic [NUM_PORTS-1:0]                creditReturn,
    output logic [NUM_PORTS*PORT_STAT_SIZE-1:0] portStatus,
    output logic [NUM_PORTS*CW-1:0]             creditCount,
    output logic [NUM_PORTS-1:0]                errUnderflow,
    output logic [NUM_PORTS-1:0]                errOverflow
);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        port_req_t w_req;

        assign w_req.link_enable   = linkEnable[i];
        assign w_req.flit_sent     = flitSent[i];
        assign w_req.credit_return = creditReturn[i];

        port_credit_fsm #(
            .CREDIT_MAX    (CREDIT_MAX),
            .RESUME_THRESH (RESUME_THRESH),
            .CW            (CW)
        ) u_port (
            .clk             (clk),
            .rst_n           (rst_n),
            .i_req           (w_req),
            .o_status        (portStatus[i*PORT_STAT_SIZE +: PORT_STAT_SIZE]),
            .o_credit_count  (creditCount[i*CW +: CW]),
            .o_err_underflow (errUnderflow[i]),
            .o_err_overflow  (errOverflow[i])
        );
    end

endmodule

// File: tb/tb_port_status_ctrl.sv
// Self-checking bench for port_status_ctrl: directed scenarios plus random traffic vs a behavioural model.
module tb_port_status_ctrl;
    import port_status_ctrl_pkg::*;

    localparam int CMAX = 4;
    localparam int CWB  = 3;
`ifdef STATUS_HYST_EN
    localparam int RESUME = 2;
`else
    localparam int RESUME = 1;
`endif
    localparam int M_OFF = 0, M_ON = 1, M_STALL = 2, M_DRAIN = 3;

    logic                                clk = 1'b0;
    logic                                rst_n;
    logic [3:0]                          linkEnable, flitSent, creditReturn;
    logic [NUM_PORTS*PORT_STAT_SIZE-1:0] portStatus;
    logic [NUM_PORTS*CWB-1:0]            creditCount;
    logic [3:0]                          errUnderflow, errOverflow;

    int vectors = 0;
    int miscompares = 0;

    int m_cnt[4];
    int m_st[4];
    bit m_uf[4];
    bit m_of[4];
    logic [3:0] cur_en;

    port_status_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .linkEnable   (linkEnable),
        .flitSent     (flitSent),
        .creditReturn (creditReturn),
        .portStatus   (portStatus),
        .creditCount  (creditCount),
        .errUnderflow (errUnderflow),
        .errOverflow  (errOverflow)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = CMAX; m_st[i] = M_OFF; m_uf[i] = 0; m_of[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic [3:0] en, input logic [3:0] fs, input logic [3:0] cr);
        for (int i = 0; i < 4; i++) begin
            int nxt;
            nxt = m_cnt[i] - int'(fs[i]) + int'(cr[i]);
            if (nxt < 0)    begin nxt = 0;    m_uf[i] = 1; end
            if (nxt > CMAX) begin nxt = CMAX; m_of[i] = 1; end
            case (m_st[i])
                M_OFF:   if (en[i] && nxt == CMAX) m_st[i] = M_ON;
                M_ON:    if (!en[i]) m_st[i] = M_DRAIN; else if (nxt == 0) m_st[i] = M_STALL;
                M_STALL: if (!en[i]) m_st[i] = M_DRAIN; else if (nxt >= RESUME) m_st[i] = M_ON;
                default: if (nxt == CMAX) m_st[i] = M_OFF; else if (en[i]) m_st[i] = M_ON;
            endcase
            m_cnt[i] = nxt;
        end
    endfunction

    function automatic logic [NUM_PORTS*PORT_STAT_SIZE-1:0] exp_status();
        logic [NUM_PORTS*PORT_STAT_SIZE-1:0] v;
        for (int i = 0; i < 4; i++)
            v[i*PORT_STAT_SIZE +: PORT_STAT_SIZE] = (m_st[i] == M_ON) ? STAT_ACTIVE : STAT_INACTIVE;
        return v;
    endfunction

    function automatic logic [NUM_PORTS*CWB-1:0] exp_count();
        logic [NUM_PORTS*CWB-1:0] v;
        for (int i = 0; i < 4; i++) v[i*CWB +: CWB] = CWB'(m_cnt[i]);
        return v;
    endfunction

    function automatic logic [3:0] exp_uf();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_uf[i];
        return v;
    endfunction

    function automatic logic [3:0] exp_of();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_of[i];
        return v;
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, return #1 after it.
    task automatic cycle(input logic [3:0] en, input logic [3:0] fs, input logic [3:0] cr);
        linkEnable = en; flitSent = fs; creditReturn = cr; cur_en = en;
        @(posedge clk);
        model_step(en, fs, cr);
        #1;
        flitSent = '0; creditReturn = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; linkEnable = '0; flitSent = '0; creditReturn = '0; cur_en = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (portStatus !== {NUM_PORTS{STAT_INACTIVE}}) begin
            $display("FAIL reset_status: got %h want %h", portStatus, {NUM_PORTS{STAT_INACTIVE}}); miscompares++;
        end
        vectors++;
        if (creditCount !== exp_count()) begin
            $display("FAIL reset_count: got %h want %h", creditCount, exp_count()); miscompares++;
        end
        vectors++;
        if ({errUnderflow, errOverflow} !== 8'h00) begin
            $display("FAIL reset_err: got uf=%b of=%b want 0", errUnderflow, errOverflow); miscompares++;
        end
    endtask

    task automatic test_enable();
        cycle(4'hF, 4'h0, 4'h0);
        vectors++;
        if (portStatus !== {NUM_PORTS{STAT_ACTIVE}}) begin
            $display("FAIL enable_status: got %h want %h", portStatus, {NUM_PORTS{STAT_ACTIVE}}); miscompares++;
        end
        vectors++;
        if (creditCount !== 12'o4444) begin
            $display("FAIL enable_count: got %o want 4444", creditCount); miscompares++;
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            cycle(4'hF, 4'b0100, 4'h0);
            vectors++;
            if (int'(creditCount[2*CWB +: CWB]) !== 3 - k) begin
                $display("FAIL stall_count%0d: got %0d want %0d", k, creditCount[2*CWB +: CWB], 3 - k); miscompares++;
            end
            vectors++;
            if (portStatus !== exp_status()) begin
                $display("FAIL stall_status%0d: got %h want %h", k, portStatus, exp_status()); miscompares++;
            end
        end
        vectors++;
        if (portStatus[2*PORT_STAT_SIZE +: PORT_STAT_SIZE] !== STAT_INACTIVE || m_st[2] != M_STALL) begin
            $display("FAIL stall_port2: got %h want %h", portStatus[2*PORT_STAT_SIZE +: PORT_STAT_SIZE], STAT_INACTIVE); miscompares++;
        end
    endtask

    task automatic test_resume();
        logic [PORT_STAT_SIZE-1:0] want;
        cycle(4'hF, 4'h0, 4'b0100);
        want = (RESUME == 1) ? STAT_ACTIVE : STAT_INACTIVE;
        vectors++;
        if (portStatus[2*PORT_STAT_SIZE +: PORT_STAT_SIZE] !== want) begin
            $display("FAIL resume_first: got %h want %h", portStatus[2*PORT_STAT_SIZE +: PORT_STAT_SIZE], want); miscompares++;
        end
        for (int k = 0; k < 3; k++) begin
            cycle(4'hF, 4'h0, 4'b0100);
            vectors++;
            if (portStatus !== exp_status() || creditCount !== exp_count()) begin
                $display("FAIL resume_refill%0d: got st=%h cnt=%o want st=%h cnt=%o",
                         k, portStatus, creditCount, exp_status(), exp_count()); miscompares++;
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(4'hF, 4'b0001, 4'h0);
        cycle(4'hF, 4'b0001, 4'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(4'hF, 4'b0001, 4'b0001);
            vectors++;
            if (creditCount[0 +: CWB] !== 3'd2 || portStatus[0 +: PORT_STAT_SIZE] !== STAT_ACTIVE) begin
                $display("FAIL b2b_port0_%0d: got cnt=%0d st=%h want cnt=2 st=%h",
                         k, creditCount[0 +: CWB], portStatus[0 +: PORT_STAT_SIZE], STAT_ACTIVE); miscompares++;
            end
        end
        vectors++;
        if (errUnderflow !== 4'h0 || errOverflow !== 4'h0) begin
            $display("FAIL b2b_err: got uf=%b of=%b want 0", errUnderflow, errOverflow); miscompares++;
        end
    endtask

    task automatic test_drain();
        repeat (3) cycle(4'hF, 4'b0010, 4'h0);
        cycle(4'b1101, 4'h0, 4'h0);
        vectors++;
        if (portStatus[1*PORT_STAT_SIZE +: PORT_STAT_SIZE] !== STAT_INACTIVE || creditCount[1*CWB +: CWB] !== 3'd1) begin
            $display("FAIL drain_enter: got st=%h cnt=%0d want st=%h cnt=1",
                     portStatus[1*PORT_STAT_SIZE +: PORT_STAT_SIZE], creditCount[1*CWB +: CWB], STAT_INACTIVE); miscompares++;
        end
        repeat (3) cycle(4'b1101, 4'h0, 4'b0010);
        vectors++;
        if (portStatus !== exp_status() || m_st[1] != M_OFF || creditCount[1*CWB +: CWB] !== 3'd4) begin
            $display("FAIL drain_off: got st=%h cnt=%o want st=%h cnt=%o",
                     portStatus, creditCount, exp_status(), exp_count()); miscompares++;
        end
        cycle(4'hF, 4'h0, 4'h0);
        vectors++;
        if (portStatus[1*PORT_STAT_SIZE +: PORT_STAT_SIZE] !== STAT_ACTIVE) begin
            $display("FAIL drain_reenable: got %h want %h", portStatus[1*PORT_STAT_SIZE +: PORT_STAT_SIZE], STAT_ACTIVE); miscompares++;
        end
    endtask

    task automatic test_errors();
        repeat (4) cycle(4'hF, 4'b1000, 4'h0);
        cycle(4'hF, 4'b1000, 4'h0);
        cycle(4'hF, 4'h0, 4'h0);
        vectors++;
        if (errUnderflow !== 4'b1000 || creditCount[3*CWB +: CWB] !== 3'd0) begin
            $display("FAIL underflow_sticky: got uf=%b cnt=%0d want uf=1000 cnt=0",
                     errUnderflow, creditCount[3*CWB +: CWB]); miscompares++;
        end
        repeat (2) cycle(4'hF, 4'h0, 4'b0001);
        cycle(4'hF, 4'h0, 4'b0001);
        vectors++;
        if (errOverflow !== 4'b0001 || creditCount[0 +: CWB] !== 3'd4) begin
            $display("FAIL overflow: got of=%b cnt=%0d want of=0001 cnt=4", errOverflow, creditCount[0 +: CWB]); miscompares++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (portStatus !== {NUM_PORTS{STAT_INACTIVE}} || creditCount !== 12'o4444 ||
            errUnderflow !== 4'h0 || errOverflow !== 4'h0) begin
            $display("FAIL async_reset: got st=%h cnt=%o uf=%b of=%b want all inactive, 4444, 0",
                     portStatus, creditCount, errUnderflow, errOverflow); miscompares++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] en;
        en = 4'hF;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
            cycle(en, 4'($urandom), 4'($urandom));
            vectors++;
            if (portStatus !== exp_status() || creditCount !== exp_count() ||
                errUnderflow !== exp_uf() || errOverflow !== exp_of()) begin
                $display("FAIL random_%0d: got st=%h cnt=%o uf=%b of=%b want st=%h cnt=%o uf=%b of=%b",
                         k, portStatus, creditCount, errUnderflow, errOverflow,
                         exp_status(), exp_count(), exp_uf(), exp_of()); miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_stall();
        test_resume();
        test_back_to_back();
        test_drain();
        test_errors();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
